sha256_round_core: RTL and testbench

//  Consumer end of the message-schedule interface. Drives the round counter and

---
 rtl/sha256_round_core_if.sv | 47 ++++
 rtl/sha256_round_core.sv | 177 +++++++++++++++++
 tb/tb_sha256_round_core.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_round_core_if.sv
// ---------------------------------------------------------------------------
// sha256_round_core_if
//   Bundles every signal of sha256_round_core except clk/rst.
//   master : the round core itself (consumes Wt, produces the digest).
//   slave  : the surroundings, i.e. the schedule block plus the hash/nonce
//            controller that issues start/h_in and collects h_out/done.
//
//   Handshake: start is a request sampled only while the core is idle; it is
//   not queued and is ignored while busy. done is a single-cycle pulse that
//   marks h_out valid. wt_in must be valid combinationally in every cycle with
//   sched_en=1 and is the word for round index r_cntr; the schedule advances
//   once per sched_en cycle.
//
//   Signals
//     start     1   begin a block (slave -> master)
//     h_in      256 chaining value, H0 in [255:224] (slave -> master)
//     wt_in     32  schedule word Wt (slave -> master)
//     r_cntr    6   current round index t (master -> slave)
//     sched_en  1   schedule enable, high only while rounds run
//     busy      1   high while rounds or the final add run
//     done      1   one-cycle pulse, h_out valid
//     h_out     256 H_in + a..h per word, H0 in [255:224]
//     core_id   4   static core index for multi-core setups
//     state_dbg 2   FSM state (0 idle, 1 round, 2 final)
// ---------------------------------------------------------------------------
interface sha256_round_core_if;
    logic         start;
    logic [255:0] h_in;
    logic [31:0]  wt_in;
    logic [5:0]   r_cntr;
    logic         sched_en;
    logic         busy;
    logic         done;
    logic [255:0] h_out;
    logic [3:0]   core_id;
    logic [1:0]   state_dbg;

    modport master (
        input  start, h_in, wt_in,
        output r_cntr, sched_en, busy, done, h_out, core_id, state_dbg
    );

    modport slave (
        output start, h_in, wt_in,
        input  r_cntr, sched_en, busy, done, h_out, core_id, state_dbg
    );
endinterface

// File: rtl/sha256_round_core.sv
// ---------------------------------------------------------------------------
// sha256_round_core
//   Runs the SHA-256 compression rounds for one 512-bit block at a time.
//   The message schedule lives in a separate block; this core drives its
//   round counter and enable and consumes one Wt per round cycle. After
//   NROUNDS rounds the chaining value is added back and presented on h_out
//   together with a one-cycle done pulse.
//
//   Ports
//     clk  in  clock, all state changes on posedge
//     rst  in  asynchronous active-high reset
//     bus  sha256_round_core_if.master (start/h_in/wt_in in,
//          r_cntr/sched_en/busy/done/h_out/core_id/state_dbg out)
// ---------------------------------------------------------------------------
module sha256_round_core #(
    parameter logic [3:0] CORE    = 4'b0,
    parameter int         NROUNDS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    sha256_round_core_if.master  bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2} state_t;

    localparam logic [5:0] LAST_ROUND = 6'(NROUNDS - 1);

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t state_q, state_d;

    // Working registers packed so that {a,b,c,d,e,f,g,h} lines up with the
    // H0..H7 layout of h_in/h_out: word 7 is a, word 0 is h.
    logic [7:0][31:0] work_q, work_d;
    logic [7:0][31:0] hreg_q, hreg_d;
    logic [7:0][31:0] h_out_q, h_out_d;
    logic [7:0][31:0] h_sum;
    logic [7:0][31:0] round_next;
    logic [5:0]       r_cntr_q, r_cntr_d;
    logic             done_q, done_d;

    logic [31:0] wa, wb, wc, wd, we, wf, wg, wh;
    logic [31:0] big_s0, big_s1, ch, maj, t1, t2;

    assign wa = work_q[7];
    assign wb = work_q[6];
    assign wc = work_q[5];
    assign wd = work_q[4];
    assign we = work_q[3];
    assign wf = work_q[2];
    assign wg = work_q[1];
    assign wh = work_q[0];

    assign big_s1 = ror(we, 6) ^ ror(we, 11) ^ ror(we, 25);
    assign big_s0 = ror(wa, 2) ^ ror(wa, 13) ^ ror(wa, 22);
    assign ch     = (we & wf) ^ (~we & wg);
    assign maj    = (wa & wb) ^ (wa & wc) ^ (wb & wc);
    assign t1     = wh + big_s1 + ch + K_ROM[r_cntr_q] + bus.wt_in;
    assign t2     = big_s0 + maj;

    assign round_next = {t1 + t2, wa, wb, wc, wd + t1, we, wf, wg};

    always_comb begin
        h_sum = '0;
        for (int i = 0; i < 8; i++) begin
            h_sum[i] = hreg_q[i] + work_q[i];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = ROUND;
            ROUND:   if (r_cntr_q == LAST_ROUND) state_d = FINAL;
            FINAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.sched_en = 1'b0;
        bus.busy     = 1'b0;
        case (state_q)
            ROUND: begin
                bus.sched_en = 1'b1;
                bus.busy     = 1'b1;
            end
            FINAL:   bus.busy = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values
    always_comb begin
        work_d   = work_q;
        hreg_d   = hreg_q;
        h_out_d  = h_out_q;
        r_cntr_d = r_cntr_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    hreg_d   = bus.h_in;
                    work_d   = bus.h_in;
                    r_cntr_d = '0;
                end
            end
            ROUND: begin
                work_d = round_next;
                // Parked at 0 on the last round so the counter never wraps
                // into a stale index during FINAL.
                r_cntr_d = (r_cntr_q == LAST_ROUND) ? 6'd0 : r_cntr_q + 6'd1;
            end
            FINAL: begin
                h_out_d  = h_sum;
                done_d   = 1'b1;
                r_cntr_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q   <= '0;
            hreg_q   <= '0;
            h_out_q  <= '0;
            r_cntr_q <= '0;
            done_q   <= 1'b0;
        end else begin
            work_q   <= work_d;
            hreg_q   <= hreg_d;
            h_out_q  <= h_out_d;
            r_cntr_q <= r_cntr_d;
            done_q   <= done_d;
        end
    end

    assign bus.r_cntr    = r_cntr_q;
    assign bus.done      = done_q;
    assign bus.h_out     = h_out_q;
    assign bus.core_id   = CORE;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_sha256_round_core.sv
// ---------------------------------------------------------------------------
// tb_sha256_round_core
//   Bench for sha256_round_core. Plays the role of the schedule block (Wt
//   expanded here from the 16-word block) and of the controller. Expected
//   digests are pushed when a block is started and popped on done.
// ---------------------------------------------------------------------------
module tb_sha256_round_core;

    localparam int NROUNDS = 64;
    localparam int BLOCK_CYC = NROUNDS + 2;

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_D =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [255:0] EMPTY_D =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    sha256_round_core_if bus();

    sha256_round_core #(.CORE(4'd3), .NROUNDS(NROUNDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- schedule model ----------------
    logic [31:0] cur_w [64];
    logic [31:0] junk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic load_block(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) cur_w[i] = blk[511 - 32*i -: 32];
        for (int t = 16; t < 64; t++)
            cur_w[t] = ssig1(cur_w[t-2]) + cur_w[t-7] + ssig0(cur_w[t-15]) + cur_w[t-16];
    endtask

    always @(negedge clk) junk = $urandom;

    always_comb begin
        bus.wt_in = junk;
        if (bus.sched_en) bus.wt_in = cur_w[bus.r_cntr];
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [255:0] exp_q[$];
    int done_cyc[$];
    int done_cnt  = 0;
    int sched_cnt = 0;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (bus.sched_en) sched_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
                if (exp_q.size() == 0) check("done_unexpected", 256'(bus.done), 256'(1'b0));
                else check("h_out", bus.h_out, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    int s0;

    task automatic start_block(input logic [255:0] h, input logic [511:0] blk,
                               input logic [255:0] exp);
        @(negedge clk);
        load_block(blk);
        bus.h_in  = h;
        bus.start = 1'b1;
        exp_q.push_back(exp);
        sched_cnt = 0;
        s0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        check(tag, 256'(done_cnt), 256'(target));
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(1, 6)) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int p1, p2;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.h_in  = '0;
        load_block(ABC_BLK);

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy",   256'(bus.busy),     256'(0));
        check("rst_sched",  256'(bus.sched_en), 256'(0));
        check("rst_done",   256'(bus.done),     256'(0));
        check("rst_r_cntr", 256'(bus.r_cntr),   256'(0));
        check("rst_h_out",  bus.h_out,          256'(0));
        check("core_id",    256'(bus.core_id),  256'(3));
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 256'(bus.state_dbg), 256'(0));

        // "abc" block: latency and sched_en count
        idle_gap();
        base = done_cnt;
        start_block(IV, ABC_BLK, ABC_D);
        wait_done(base + 1, 200, "abc_done");
        check("abc_latency", 256'(done_cyc[$] - s0), 256'(BLOCK_CYC));
        check("abc_sched_cnt", 256'(sched_cnt), 256'(NROUNDS));
        @(negedge clk);
        check("done_pulse_low", 256'(bus.done), 256'(0));
        check("h_out_hold", bus.h_out, ABC_D);

        // Abort mid-block with an asynchronous reset between edges
        idle_gap();
        base = done_cnt;
        start_block(IV, ABC_BLK, ABC_D);
        repeat (30) @(posedge clk);
        #2;
        check("r_cntr_mid", 256'(bus.r_cntr), 256'(30));
        check("busy_mid", 256'(bus.busy), 256'(1));
        #1 rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        check("async_busy",   256'(bus.busy),      256'(0));
        check("async_sched",  256'(bus.sched_en),  256'(0));
        check("async_r_cntr", 256'(bus.r_cntr),    256'(0));
        check("async_h_out",  bus.h_out,           256'(0));
        check("async_state",  256'(bus.state_dbg), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("abort_no_done", 256'(done_cnt), 256'(base));
        start_block(IV, ABC_BLK, ABC_D);
        wait_done(base + 1, 200, "abort_restart_done");

        // Spurious starts while busy are ignored
        idle_gap();
        base = done_cnt;
        p1 = $urandom_range(5, 20);
        p2 = $urandom_range(30, 55);
        start_block(IV, ABC_BLK, ABC_D);
        repeat (p1) @(negedge clk);
        bus.start = 1'b1;
        bus.h_in  = {8{$urandom}};
        @(negedge clk);
        bus.start = 1'b0;
        repeat (p2 - p1) @(negedge clk);
        bus.start = 1'b1;
        bus.h_in  = {8{$urandom}};
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(base + 1, 200, "busy_start_done");
        repeat (BLOCK_CYC + 10) @(negedge clk);
        check("busy_start_one_done", 256'(done_cnt), 256'(base + 1));
        check("busy_start_sched_cnt", 256'(sched_cnt), 256'(NROUNDS));

        // Back-to-back with start held: new block accepted in each done cycle
        idle_gap();
        base = done_cnt;
        @(negedge clk);
        load_block(ABC_BLK);
        bus.h_in  = IV;
        bus.start = 1'b1;
        sched_cnt = 0;
        s0 = cyc;
        repeat (3) exp_q.push_back(ABC_D);
        repeat (2 * BLOCK_CYC + 1) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(base + 3, 300, "b2b_done");
        check("b2b_first_latency", 256'(done_cyc[$-2] - s0), 256'(BLOCK_CYC));
        check("b2b_gap1", 256'(done_cyc[$-1] - done_cyc[$-2]), 256'(BLOCK_CYC));
        check("b2b_gap2", 256'(done_cyc[$] - done_cyc[$-1]), 256'(BLOCK_CYC));
        repeat (BLOCK_CYC + 4) @(negedge clk);
        check("b2b_no_fourth", 256'(done_cnt), 256'(base + 3));
        check("b2b_sched_cnt", 256'(sched_cnt), 256'(3 * NROUNDS));

        // Empty-message block
        idle_gap();
        base = done_cnt;
        start_block(IV, EMPTY_BLK, EMPTY_D);
        wait_done(base + 1, 200, "empty_done");
        check("empty_latency", 256'(done_cyc[$] - s0), 256'(BLOCK_CYC));

        repeat (4) @(negedge clk);
        check("queue_empty", 256'(exp_q.size()), 256'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
